yadmc_phase_cal: RTL and testbench

Phase-shift calibration initiator for the yadmc clock generator's DCM phase-shift control port (ps_ready / ps_up / ps_down). It sweeps the write-clock phase one DCM tap at a time and requests a pass/fail test from the memory test engine at each tap. It records the passing window, then parks the phase at the window centre. It runs in the clkgen `clk` (PSCLK) domain and is started once after `locked`, or again on recalibration request.

---
 rtl/yadmc_phase_cal.sv | 136 +++++++++++++
 tb/tb_yadmc_phase_cal.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/yadmc_phase_cal.sv
// yadmc_phase_cal: sweeps DCM phase taps, records the passing window and parks at its centre
module yadmc_phase_cal #(
  parameter int MAX_TAPS = 127,
  parameter int POS_W    = 9,
  parameter int SETTLE   = 16,
  parameter int SETTLE_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ps_ready,
  output logic             ps_up,
  output logic             ps_down,
  output logic             test_req,
  input  logic             test_ack,
  input  logic             test_pass,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] window_lo,
  output logic [POS_W-1:0] window_hi
);
  typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_SETTLE, S_TEST, S_MOVE, S_PS_HOLD, S_PS_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {SWEEP_UP, SWEEP_DOWN, CENTER} phase_t;
  localparam logic signed [POS_W-1:0] MAX_S = POS_W'(MAX_TAPS);
  localparam logic signed [POS_W-1:0] ONE   = POS_W'(1);
  state_t                  state_q;
  phase_t                  phase_q;
  logic signed [POS_W-1:0] pos_q, lo_q, hi_q, tgt_q, mid_fail, mid_pass;
  logic signed [POS_W:0]   sum_fail, sum_pass;
  logic [SETTLE_W-1:0]     cnt_q;
  logic                    ps_up_q, ps_down_q, test_req_q, busy_q, done_q, error_q;
  // Window centre, floored; the pass variant folds in the tap being recorded as the new low edge
  always_comb begin
    sum_fail = {lo_q[POS_W-1], lo_q} + {hi_q[POS_W-1], hi_q};
    sum_pass = {pos_q[POS_W-1], pos_q} + {hi_q[POS_W-1], hi_q};
    mid_fail = sum_fail[POS_W:1];
    mid_pass = sum_pass[POS_W:1];
  end
  // Calibration sequencer with registered handshake and status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= SWEEP_UP;
      pos_q      <= '0;
      lo_q       <= '0;
      hi_q       <= '0;
      tgt_q      <= '0;
      cnt_q      <= '0;
      ps_up_q    <= 1'b0;
      ps_down_q  <= 1'b0;
      test_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          busy_q  <= 1'b1;
          error_q <= 1'b0;
          pos_q   <= '0;
          lo_q    <= '0;
          hi_q    <= '0;
          phase_q <= SWEEP_UP;
          state_q <= S_WAIT_RDY;
        end
        S_WAIT_RDY: if (ps_ready) begin
          cnt_q   <= SETTLE_W'(SETTLE);
          state_q <= S_SETTLE;
        end
        S_SETTLE: if (cnt_q == '0) begin
          test_req_q <= 1'b1;
          state_q    <= S_TEST;
        end else cnt_q <= cnt_q - 1'b1;
        S_TEST: if (test_ack) begin
          test_req_q <= 1'b0;
          state_q    <= S_MOVE;
          if (phase_q == SWEEP_UP) begin
            if (!test_pass && pos_q == '0) begin
              error_q <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else if (test_pass && pos_q < MAX_S) begin
              hi_q  <= pos_q;
              tgt_q <= pos_q + ONE;
            end else begin
              if (test_pass) hi_q <= pos_q;
              tgt_q   <= '1;
              phase_q <= SWEEP_DOWN;
            end
          end else if (test_pass && pos_q > -MAX_S) begin
            lo_q  <= pos_q;
            tgt_q <= pos_q - ONE;
          end else begin
            if (test_pass) lo_q <= pos_q;
            tgt_q   <= test_pass ? mid_pass : mid_fail;
            phase_q <= CENTER;
          end
        end
        S_MOVE: if (pos_q == tgt_q) begin
          if (phase_q == CENTER) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_DONE;
          end else state_q <= S_WAIT_RDY;
        end else if (ps_ready) begin
          ps_up_q   <= tgt_q > pos_q;
          ps_down_q <= tgt_q < pos_q;
          state_q   <= S_PS_HOLD;
        end
        S_PS_HOLD: if (!ps_ready) begin
          ps_up_q   <= 1'b0;
          ps_down_q <= 1'b0;
          pos_q     <= ps_up_q ? pos_q + ONE : pos_q - ONE;
          state_q   <= S_PS_WAIT;
        end
        S_PS_WAIT: if (ps_ready) state_q <= S_MOVE;
        default: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
  assign ps_up     = ps_up_q;
  assign ps_down   = ps_down_q;
  assign test_req  = test_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign pos       = pos_q;
  assign window_lo = lo_q;
  assign window_hi = hi_q;
endmodule

// File: tb/tb_yadmc_phase_cal.sv
// tb_yadmc_phase_cal: directed checks of the phase calibrator against a clkgen and test-engine model
module tb_yadmc_phase_cal;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  // Instance 0 sweeps up to 127 taps, instance 1 is limited to 4 taps
  for (genvar g = 0; g < 2; g++) begin : m
    logic start = 1'b0;
    logic ps_ready, test_ack, test_pass, ps_up, ps_down, test_req, busy, done, error;
    logic signed [8:0] pos, wlo, whi;
    int ups = 0, downs = 0, tests = 0, dones = 0, tmin = 0, tmax = 0;
    int lo_w = 0, hi_w = 0, drop = 1;
    yadmc_phase_cal #(.MAX_TAPS(g == 0 ? 127 : 4), .POS_W(9), .SETTLE(4), .SETTLE_W(8)) dut (
      .clk(clk), .reset(reset), .start(start), .ps_ready(ps_ready), .ps_up(ps_up),
      .ps_down(ps_down), .test_req(test_req), .test_ack(test_ack), .test_pass(test_pass),
      .busy(busy), .done(done), .error(error), .pos(pos), .window_lo(wlo), .window_hi(whi));
    // clkgen: drop ready after a request, return it 8 cycles after release
    initial begin
      ps_ready = 1'b1;
      forever begin
        @(negedge clk);
        if (ps_ready && (ps_up || ps_down)) begin
          if (ps_up) ups++;
          else downs++;
          repeat (drop) @(negedge clk);
          ps_ready = 1'b0;
          @(negedge clk);
          while (ps_up || ps_down) @(negedge clk);
          repeat (7) @(negedge clk);
          ps_ready = 1'b1;
        end
      end
    end
    // test engine: pass when pos lies inside [lo_w, hi_w]
    initial begin
      test_ack = 1'b0;
      test_pass = 1'b0;
      forever begin
        @(negedge clk);
        if (test_req) begin
          repeat (2) @(negedge clk);
          tests++;
          if (pos > tmax) tmax = pos;
          if (pos < tmin) tmin = pos;
          test_pass = (pos >= lo_w) && (pos <= hi_w);
          test_ack = 1'b1;
          @(negedge clk);
          test_ack = 1'b0;
          test_pass = 1'b0;
        end
      end
    end
    initial forever begin
      @(negedge clk);
      if (done) dones++;
    end
  end

  task automatic cal0(input int lo, input int hi, output bit ok, output int du, output int dd, output int dn);
    int u, d, n;
    u = m[0].ups; d = m[0].downs; n = m[0].dones;
    m[0].lo_w = lo; m[0].hi_w = hi;
    m[0].start = 1'b1;
    @(negedge clk);
    m[0].start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = m[0].done;
    end
    repeat (3) @(negedge clk);
    du = m[0].ups - u; dd = m[0].downs - d; dn = m[0].dones - n;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m[0].ps_up, m[0].ps_down, m[0].test_req, m[0].busy, m[0].done, m[0].error} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl0: got %b expected 000000", {m[0].ps_up, m[0].ps_down, m[0].test_req, m[0].busy, m[0].done, m[0].error});
    end
    checks++;
    if ({m[0].pos, m[0].wlo, m[0].whi} !== 27'b0) begin
      failures++; $display("FAIL reset_pos0: got %0d %0d %0d expected 0 0 0", m[0].pos, m[0].wlo, m[0].whi);
    end
    checks++;
    if ({m[1].ps_up, m[1].ps_down, m[1].test_req, m[1].busy, m[1].done, m[1].error} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl1: got %b expected 000000", {m[1].ps_up, m[1].ps_down, m[1].test_req, m[1].busy, m[1].done, m[1].error});
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_window();
    bit ok; int du, dd, dn;
    cal0(-3, 5, ok, du, dd, dn);
    checks++; if (!ok) begin failures++; $display("FAIL window_done: got timeout expected done"); end
    checks++; if (m[0].pos !== 1) begin failures++; $display("FAIL window_pos: got %0d expected 1", m[0].pos); end
    checks++; if (m[0].wlo !== -3) begin failures++; $display("FAIL window_lo: got %0d expected -3", m[0].wlo); end
    checks++; if (m[0].whi !== 5) begin failures++; $display("FAIL window_hi: got %0d expected 5", m[0].whi); end
    checks++; if (m[0].error !== 1'b0) begin failures++; $display("FAIL window_error: got %b expected 0", m[0].error); end
    checks++; if (du !== 11) begin failures++; $display("FAIL window_ups: got %0d expected 11", du); end
    checks++; if (dd !== 10) begin failures++; $display("FAIL window_downs: got %0d expected 10", dd); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL window_dones: got %0d expected 1", dn); end
  endtask

  task automatic test_error();
    bit ok; int du, dd, dn;
    cal0(1, 5, ok, du, dd, dn);
    checks++; if (!ok) begin failures++; $display("FAIL error_done: got timeout expected done"); end
    checks++; if (m[0].error !== 1'b1) begin failures++; $display("FAIL error_flag: got %b expected 1", m[0].error); end
    checks++; if (du + dd !== 0) begin failures++; $display("FAIL error_moves: got %0d expected 0", du + dd); end
    checks++; if (m[0].pos !== 0) begin failures++; $display("FAIL error_pos: got %0d expected 0", m[0].pos); end
    checks++; if (dn !== 1) begin failures++; $display("FAIL error_dones: got %0d expected 1", dn); end
  endtask

  task automatic test_max_taps();
    bit ok = 1'b0;
    m[1].lo_w = -100; m[1].hi_w = 100;
    m[1].start = 1'b1;
    @(negedge clk);
    m[1].start = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = m[1].done;
    end
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL max_done: got timeout expected done"); end
    checks++; if (m[1].whi !== 4) begin failures++; $display("FAIL max_hi: got %0d expected 4", m[1].whi); end
    checks++; if (m[1].wlo !== -4) begin failures++; $display("FAIL max_lo: got %0d expected -4", m[1].wlo); end
    checks++; if (m[1].pos !== 0) begin failures++; $display("FAIL max_pos: got %0d expected 0", m[1].pos); end
    checks++; if (m[1].tmax !== 4 || m[1].tmin !== -4) begin failures++; $display("FAIL max_range: got %0d..%0d expected -4..4", m[1].tmin, m[1].tmax); end
    checks++; if (m[1].tests !== 9) begin failures++; $display("FAIL max_tests: got %0d expected 9", m[1].tests); end
  endtask

  task automatic test_handshake();
    bit found = 1'b0, ok = 1'b0;
    int u = m[0].ups, n = m[0].dones;
    m[0].drop = 5; m[0].lo_w = -1; m[0].hi_w = 1;
    m[0].start = 1'b1;
    @(negedge clk);
    m[0].start = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = m[0].ps_up;
    end
    checks++; if (!found) begin failures++; $display("FAIL hs_up: got timeout expected ps_up"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (m[0].ps_up !== 1'b1 || m[0].ps_ready !== 1'b1 || m[0].pos !== 0) begin
        failures++; $display("FAIL hs_hold%0d: got up=%b rdy=%b pos=%0d expected 1 1 0", i, m[0].ps_up, m[0].ps_ready, m[0].pos);
      end
      m[0].start = (i == 1);
      @(negedge clk);
    end
    m[0].start = 1'b0;
    m[0].drop = 1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      ok = m[0].done;
    end
    repeat (3) @(negedge clk);
    checks++; if (!ok) begin failures++; $display("FAIL hs_done: got timeout expected done"); end
    checks++; if (m[0].pos !== 0 || m[0].wlo !== -1 || m[0].whi !== 1) begin failures++; $display("FAIL hs_result: got %0d [%0d,%0d] expected 0 [-1,1]", m[0].pos, m[0].wlo, m[0].whi); end
    checks++; if (m[0].ups - u !== 4) begin failures++; $display("FAIL hs_ups: got %0d expected 4", m[0].ups - u); end
    checks++; if (m[0].dones - n !== 1) begin failures++; $display("FAIL hs_dones: got %0d expected 1", m[0].dones - n); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    m[0].lo_w = -3; m[0].hi_w = 5;
    m[0].start = 1'b1;
    @(negedge clk);
    m[0].start = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      found = m[0].ps_up && (m[0].pos == 2);
    end
    checks++; if (!found) begin failures++; $display("FAIL rst_hold: got timeout expected ps_up at pos 2"); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({m[0].ps_up, m[0].ps_down, m[0].busy} !== 3'b0) begin failures++; $display("FAIL rst_ctrl: got %b expected 000", {m[0].ps_up, m[0].ps_down, m[0].busy}); end
    checks++; if (m[0].pos !== 0) begin failures++; $display("FAIL rst_pos: got %0d expected 0", m[0].pos); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_floor();
    bit ok; int du, dd, dn;
    cal0(-5, 2, ok, du, dd, dn);
    checks++; if (!ok || dn !== 1) begin failures++; $display("FAIL floor_a_done: got ok=%b dones=%0d expected 1 1", ok, dn); end
    checks++; if (m[0].pos !== -2) begin failures++; $display("FAIL floor_a_pos: got %0d expected -2", m[0].pos); end
    checks++; if (m[0].wlo !== -5 || m[0].whi !== 2) begin failures++; $display("FAIL floor_a_win: got [%0d,%0d] expected [-5,2]", m[0].wlo, m[0].whi); end
    cal0(-2, 5, ok, du, dd, dn);
    checks++; if (!ok) begin failures++; $display("FAIL floor_b_done: got timeout expected done"); end
    checks++; if (m[0].pos !== 1) begin failures++; $display("FAIL floor_b_pos: got %0d expected 1", m[0].pos); end
  endtask

  initial begin
    reset = 1'b1;
    test_reset();
    test_window();
    test_error();
    test_max_taps();
    test_handshake();
    test_reset_mid();
    test_floor();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
